// File: rtl/haze_frame_ctrl.sv
// haze_frame_ctrl: frame sequencer beside the haze core; double-buffers config, checks geometry, estimates A.
// Optional macro HAZE_ATM_SMOOTH_EN selects an IIR (alpha=1/4) atmospheric-light update instead of the raw frame max.
module haze_frame_ctrl #(
    parameter int PIC_WIDTH  = 640,
    parameter int PIC_HEIGHT = 480,
    parameter int DATA_W     = 8,
    parameter int ATM_INIT   = 220,
    parameter int OMEGA_INIT = 243,
    parameter int T0_INIT    = 26
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pre_frame_vsync,
    input  logic              i_pre_frame_href,
    input  logic              i_pre_frame_clken,
    input  logic              i_cfg_we,
    input  logic              i_cfg_bypass,
    input  logic [DATA_W-1:0] i_cfg_omega,
    input  logic [DATA_W-1:0] i_cfg_t0,
    input  logic              i_dark_valid,
    input  logic [DATA_W-1:0] i_dark_data,
    output logic              o_core_bypass,
    output logic [DATA_W-1:0] o_core_omega,
    output logic [DATA_W-1:0] o_core_t0,
    output logic [DATA_W-1:0] o_atm_light,
    output logic [15:0]       o_frame_cnt,
    output logic              o_geom_err,
    output logic [1:0]        o_ctrl_state
);
    typedef enum logic [1:0] {
        WAIT_VS   = 2'd0,
        ACTIVE    = 2'd1,
        FRAME_END = 2'd2,
        BLANK     = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] OMEGA_RST = DATA_W'(OMEGA_INIT);
    localparam logic [DATA_W-1:0] T0_RST    = DATA_W'(T0_INIT);
    localparam logic [DATA_W-1:0] ATM_RST   = DATA_W'(ATM_INIT);
    localparam logic [15:0]       WIDTH16   = 16'(PIC_WIDTH);
    localparam logic [15:0]       HEIGHT16  = 16'(PIC_HEIGHT);

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_vsD;
    logic              r_hrD;
    logic              w_vsRise;
    logic              w_vsFall;
    logic              w_hrFall;
    logic              w_commit;
    logic              w_frameBadFinal;
    logic              w_geomAtCommit;
    logic              r_shBypass;
    logic [DATA_W-1:0] r_shOmega;
    logic [DATA_W-1:0] r_shT0;
    logic              r_coreBypass;
    logic [DATA_W-1:0] r_coreOmega;
    logic [DATA_W-1:0] r_coreT0;
    logic [DATA_W-1:0] r_atm;
    logic [DATA_W-1:0] w_atmNext;
    logic [DATA_W-1:0] r_maxR;
    logic [15:0]       r_frameCnt;
    logic              r_geomErr;
    logic [15:0]       r_pixCnt;
    logic [15:0]       r_lineCnt;
    logic              r_frameBad;

    assign w_vsRise = i_pre_frame_vsync & ~r_vsD;
    assign w_vsFall = ~i_pre_frame_vsync & r_vsD;
    assign w_hrFall = ~i_pre_frame_href & r_hrD;
    assign w_commit = w_vsRise && (r_state != ACTIVE);

    assign w_frameBadFinal = r_frameBad | (r_lineCnt != HEIGHT16);
    // A back-to-back commit must see the verdict of the frame closing in the same cycle
    assign w_geomAtCommit  = (r_state == FRAME_END) ? w_frameBadFinal : r_geomErr;

`ifdef HAZE_ATM_SMOOTH_EN
    logic [DATA_W+1:0] w_atmSum;
    assign w_atmSum  = {2'b00, r_atm} - {4'b0000, r_atm[DATA_W-1:2]} + {4'b0000, r_maxR[DATA_W-1:2]};
    assign w_atmNext = w_atmSum[DATA_W-1:0];
`else
    assign w_atmNext = r_maxR;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= WAIT_VS;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            WAIT_VS:   if (w_vsRise) w_stateNext = ACTIVE;
            ACTIVE:    if (w_vsFall) w_stateNext = FRAME_END;
            FRAME_END: w_stateNext = w_vsRise ? ACTIVE : BLANK;
            BLANK:     if (w_vsRise) w_stateNext = ACTIVE;
            default:   w_stateNext = WAIT_VS;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Edge history follows the live sync so vsync held high through reset is not a rise
            r_vsD        <= i_pre_frame_vsync;
            r_hrD        <= i_pre_frame_href;
            r_shBypass   <= 1'b0;
            r_shOmega    <= OMEGA_RST;
            r_shT0       <= T0_RST;
            r_coreBypass <= 1'b1;
            r_coreOmega  <= OMEGA_RST;
            r_coreT0     <= T0_RST;
            r_atm        <= ATM_RST;
            r_maxR       <= '0;
            r_frameCnt   <= '0;
            r_geomErr    <= 1'b0;
            r_pixCnt     <= '0;
            r_lineCnt    <= '0;
            r_frameBad   <= 1'b0;
        end else begin
            r_vsD <= i_pre_frame_vsync;
            r_hrD <= i_pre_frame_href;
            if (i_cfg_we) begin
                r_shBypass <= i_cfg_bypass;
                r_shOmega  <= i_cfg_omega;
                r_shT0     <= i_cfg_t0;
            end
            if (w_commit) begin
                r_coreBypass <= r_shBypass | w_geomAtCommit;
                r_coreOmega  <= r_shOmega;
                r_coreT0     <= r_shT0;
                r_maxR       <= '0;
            end
            if (r_state == ACTIVE) begin
                if (w_hrFall) begin
                    if (r_pixCnt != WIDTH16) r_frameBad <= 1'b1;
                    r_pixCnt <= '0;
                    if (r_lineCnt != 16'hFFFF) r_lineCnt <= r_lineCnt + 16'd1;
                end else if (i_pre_frame_clken && i_pre_frame_href && r_pixCnt != 16'hFFFF) begin
                    r_pixCnt <= r_pixCnt + 16'd1;
                end
                // A line still open when the frame closes is a truncated line
                if (w_vsFall && i_pre_frame_href) r_frameBad <= 1'b1;
                if (i_dark_valid && i_dark_data > r_maxR) r_maxR <= i_dark_data;
            end
            if (r_state == FRAME_END) begin
                r_geomErr  <= w_frameBadFinal;
                r_frameCnt <= r_frameCnt + 16'd1;
                if (!w_frameBadFinal) r_atm <= w_atmNext;
                r_lineCnt  <= '0;
                r_pixCnt   <= '0;
                r_frameBad <= 1'b0;
            end
        end
    end

    assign o_core_bypass = r_coreBypass;
    assign o_core_omega  = r_coreOmega;
    assign o_core_t0     = r_coreT0;
    assign o_atm_light   = r_atm;
    assign o_frame_cnt   = r_frameCnt;
    assign o_geom_err    = r_geomErr;
    assign o_ctrl_state  = r_state;
endmodule

// File: tb/tb_haze_frame_ctrl.sv
// tb_haze_frame_ctrl: directed frames against a frame-level model of haze_frame_ctrl (small 8x4 geometry).
// Literal expectations follow the HAZE_ATM_SMOOTH_EN setting of the build.
module tb_haze_frame_ctrl;
    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        clken = 1'b0;
    logic        we = 1'b0;
    logic        cfgBypass = 1'b0;
    logic [7:0]  cfgOmega = 8'd243;
    logic [7:0]  cfgT0 = 8'd26;
    logic        darkValid = 1'b0;
    logic [7:0]  darkData = 8'd0;

    logic        coreBypass;
    logic [7:0]  coreOmega;
    logic [7:0]  coreT0;
    logic [7:0]  atmLight;
    logic [15:0] frameCnt;
    logic        geomErr;
    logic [1:0]  ctrlState;

    int   total = 0;
    int   bad = 0;
    logic checkEn = 1'b0;

    // Frame-level model of what the controller must present
    logic        expBypass = 1'b1;
    logic [7:0]  expOmega = 8'd243;
    logic [7:0]  expT0 = 8'd26;
    logic [7:0]  expAtm = 8'd220;
    logic [15:0] expFrameCnt = 16'd0;
    logic        expGeom = 1'b0;
    logic        shBypass = 1'b0;
    logic [7:0]  shOmega = 8'd243;
    logic [7:0]  shT0 = 8'd26;
    logic [7:0]  mMax = 8'd0;
    int          mLines = 0;
    logic        mBad = 1'b0;
    logic        mInFrame = 1'b0;
    logic        mEndPending = 1'b0;
    logic        mPrevVs = 1'b0;
    logic [7:0]  atmHeld;

    haze_frame_ctrl #(
        .PIC_WIDTH (W),
        .PIC_HEIGHT(H),
        .DATA_W    (8),
        .ATM_INIT  (220),
        .OMEGA_INIT(243),
        .T0_INIT   (26)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pre_frame_vsync(vsync),
        .i_pre_frame_href (href),
        .i_pre_frame_clken(clken),
        .i_cfg_we         (we),
        .i_cfg_bypass     (cfgBypass),
        .i_cfg_omega      (cfgOmega),
        .i_cfg_t0         (cfgT0),
        .i_dark_valid     (darkValid),
        .i_dark_data      (darkData),
        .o_core_bypass    (coreBypass),
        .o_core_omega     (coreOmega),
        .o_core_t0        (coreT0),
        .o_atm_light      (atmLight),
        .o_frame_cnt      (frameCnt),
        .o_geom_err       (geomErr),
        .o_ctrl_state     (ctrlState)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] atmUpdate(input logic [7:0] a, input logic [7:0] m);
`ifdef HAZE_ATM_SMOOTH_EN
        int v;
        v = int'(a) - int'(a) / 4 + int'(m) / 4;
        return 8'(v);
`else
        return m;
`endif
    endfunction

    task automatic resetModel();
        expBypass   = 1'b1;
        expOmega    = 8'd243;
        expT0       = 8'd26;
        expAtm      = 8'd220;
        expFrameCnt = 16'd0;
        expGeom     = 1'b0;
        shBypass    = 1'b0;
        shOmega     = 8'd243;
        shT0        = 8'd26;
        mMax        = 8'd0;
        mLines      = 0;
        mBad        = 1'b0;
        mInFrame    = 1'b0;
        mEndPending = 1'b0;
    endtask

    // One clock with the inputs currently driven; the model then absorbs that edge
    task automatic applyStimulus();
        logic frameBad;
        @(posedge clk);
        #1;
        if (rst) begin
            resetModel();
        end else begin
            if (mEndPending) begin
                frameBad = mBad || (mLines != H);
                expGeom = frameBad;
                expFrameCnt = expFrameCnt + 16'd1;
                if (!frameBad) expAtm = atmUpdate(expAtm, mMax);
                mEndPending = 1'b0;
            end
            if (vsync && !mPrevVs && !mInFrame) begin
                expBypass = shBypass | expGeom;
                expOmega  = shOmega;
                expT0     = shT0;
                mMax      = 8'd0;
                mLines    = 0;
                mBad      = 1'b0;
                mInFrame  = 1'b1;
            end
            if (!vsync && mPrevVs && mInFrame) begin
                mInFrame    = 1'b0;
                mEndPending = 1'b1;
            end
            if (we) begin
                shBypass = cfgBypass;
                shOmega  = cfgOmega;
                shT0     = cfgT0;
            end
        end
        mPrevVs = vsync;
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("core_bypass", {15'd0, coreBypass}, {15'd0, expBypass});
            checkOutput("core_omega", {8'd0, coreOmega}, {8'd0, expOmega});
            checkOutput("core_t0", {8'd0, coreT0}, {8'd0, expT0});
            checkOutput("atm_light", {8'd0, atmLight}, {8'd0, expAtm});
            checkOutput("frame_cnt", frameCnt, expFrameCnt);
            checkOutput("geom_err", {15'd0, geomErr}, {15'd0, expGeom});
        end
    end

    task automatic sendLine(input int len, input int peak);
        for (int p = 0; p < len; p++) begin
            if (p == 2) begin
                href = 1'b1; clken = 1'b0; darkValid = 1'b0;
                applyStimulus();
            end
            href = 1'b1; clken = 1'b1; darkValid = 1'b1;
            darkData = 8'((peak * (p + 1)) / len);
            if (mInFrame && darkData > mMax) mMax = darkData;
            applyStimulus();
        end
        href = 1'b0; clken = 1'b0; darkValid = 1'b0; darkData = 8'd0;
        if (mInFrame) begin
            mLines++;
            if (len != W) mBad = 1'b1;
        end
        applyStimulus();
        applyStimulus();
    endtask

    task automatic sendBody(input int nLines, input int shortIdx, input int peak);
        for (int l = 0; l < nLines; l++) sendLine((l == shortIdx) ? W - 1 : W, peak);
    endtask

    task automatic startFrame(input logic weOnRise, input logic [7:0] omega);
        vsync = 1'b1;
        if (weOnRise) begin
            we = 1'b1;
            cfgOmega = omega;
        end
        applyStimulus();
        we = 1'b0;
        applyStimulus();
    endtask

    task automatic endFrame(input logic backToBack);
        vsync = 1'b0;
        applyStimulus();
        if (backToBack) begin
            vsync = 1'b1;
            applyStimulus();
        end else begin
            applyStimulus();
            applyStimulus();
        end
    endtask

    task automatic writeCfg(input logic b, input logic [7:0] om, input logic [7:0] t0);
        cfgBypass = b; cfgOmega = om; cfgT0 = t0; we = 1'b1;
        applyStimulus();
        we = 1'b0;
        applyStimulus();
    endtask

    initial begin
        applyStimulus();
        applyStimulus();
        checkEn = 1'b1;
        rst = 1'b0;
        applyStimulus();
        checkOutput("reset_state", {14'd0, ctrlState}, 16'd0);
        checkOutput("reset_bypass", {15'd0, coreBypass}, 16'd1);
        checkOutput("reset_omega", {8'd0, coreOmega}, 16'd243);
        checkOutput("reset_atm", {8'd0, atmLight}, 16'd220);

        // Frame 1: bypass shadow set beforehand, new omega written mid-frame
        writeCfg(1'b1, 8'd243, 8'd26);
        startFrame(1'b0, 8'd0);
        checkOutput("f1_bypass", {15'd0, coreBypass}, 16'd1);
        checkOutput("f1_state", {14'd0, ctrlState}, 16'd1);
        sendBody(2, -1, 200);
        writeCfg(1'b0, 8'd200, 8'd26);
        checkOutput("f1_omega_held", {8'd0, coreOmega}, 16'd243);
        sendBody(2, -1, 200);
        endFrame(1'b0);
        checkOutput("f1_frame_cnt", frameCnt, 16'd1);
`ifdef HAZE_ATM_SMOOTH_EN
        checkOutput("f1_atm", {8'd0, atmLight}, 16'd215);
`else
        checkOutput("f1_atm", {8'd0, atmLight}, 16'd200);
`endif

        // Frame 2: config write coincident with the vsync rise lands one frame later
        startFrame(1'b1, 8'd150);
        checkOutput("f2_omega", {8'd0, coreOmega}, 16'd200);
        checkOutput("f2_bypass", {15'd0, coreBypass}, 16'd0);
        sendBody(4, -1, 200);
        endFrame(1'b0);

        startFrame(1'b0, 8'd0);
        checkOutput("f3_omega", {8'd0, coreOmega}, 16'd150);
        sendBody(4, -1, 200);
        endFrame(1'b0);
        checkOutput("f3_frame_cnt", frameCnt, 16'd3);
        checkOutput("f3_geom", {15'd0, geomErr}, 16'd0);
`ifdef HAZE_ATM_SMOOTH_EN
        checkOutput("f3_atm", {8'd0, atmLight}, 16'd209);
`else
        checkOutput("f3_atm", {8'd0, atmLight}, 16'd200);
`endif

        // Frame 4: one 7-pixel line, A must hold
        atmHeld = expAtm;
        startFrame(1'b0, 8'd0);
        sendBody(4, 1, 50);
        endFrame(1'b0);
        checkOutput("f4_geom", {15'd0, geomErr}, 16'd1);
        checkOutput("f4_atm_held", {8'd0, atmLight}, {8'd0, atmHeld});

        startFrame(1'b0, 8'd0);
        checkOutput("f5_forced_bypass", {15'd0, coreBypass}, 16'd1);
        sendBody(4, -1, 200);
        endFrame(1'b0);
        checkOutput("f5_geom", {15'd0, geomErr}, 16'd0);

        // Frame 6: reset mid-frame with vsync still high at release
        startFrame(1'b0, 8'd0);
        checkOutput("f6_bypass", {15'd0, coreBypass}, 16'd0);
        sendBody(2, -1, 200);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("rst_state", {14'd0, ctrlState}, 16'd0);
        checkOutput("rst_frame_cnt", frameCnt, 16'd0);
        checkOutput("rst_atm", {8'd0, atmLight}, 16'd220);
        sendBody(2, -1, 200);
        endFrame(1'b0);
        checkOutput("rst_no_count", frameCnt, 16'd0);
        checkOutput("rst_wait_state", {14'd0, ctrlState}, 16'd0);

        // Two frames with max 100, the second closing back-to-back into the next
        startFrame(1'b0, 8'd0);
        sendBody(4, -1, 100);
        endFrame(1'b0);
        checkOutput("f7_frame_cnt", frameCnt, 16'd1);
`ifdef HAZE_ATM_SMOOTH_EN
        checkOutput("f7_atm", {8'd0, atmLight}, 16'd190);
`else
        checkOutput("f7_atm", {8'd0, atmLight}, 16'd100);
`endif
        startFrame(1'b0, 8'd0);
        sendBody(4, -1, 100);
        endFrame(1'b1);
        checkOutput("b2b_state", {14'd0, ctrlState}, 16'd1);
        checkOutput("b2b_frame_cnt", frameCnt, 16'd2);
`ifdef HAZE_ATM_SMOOTH_EN
        checkOutput("f8_atm", {8'd0, atmLight}, 16'd168);
`else
        checkOutput("f8_atm", {8'd0, atmLight}, 16'd100);
`endif
        sendBody(4, -1, 60);
        endFrame(1'b0);
        checkOutput("f9_frame_cnt", frameCnt, 16'd3);
`ifdef HAZE_ATM_SMOOTH_EN
        checkOutput("f9_atm", {8'd0, atmLight}, 16'd141);
`else
        checkOutput("f9_atm", {8'd0, atmLight}, 16'd60);
`endif

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
